bullet_controller: RTL and testbench

BULLET_CONTROLLER -- requirements
Module: bullet_controller

---
 rtl/game_pkg.sv | 34 +++
 rtl/frame_tick.sv | 35 +++
 rtl/bullet_controller.sv | 179 +++++++++++++++++
 tb/tb_bullet_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types and constants: facing directions, bullet FSM states, sprite/arena geometry.
// Pure declarations; no logic, no latency.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_FLYING   = 2'd2,
    ST_COOLDOWN = 2'd3
  } bullet_state_t;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned COORD_MAX   = 1023;
  localparam int unsigned SPRITE_HALF = 15;
  localparam int unsigned BULLET_SIZE = 4;

  localparam int unsigned ARENA_X_MIN = 32;
  localparam int unsigned ARENA_X_MAX = 607;
  localparam int unsigned ARENA_Y_MIN = 64;
  localparam int unsigned ARENA_Y_MAX = 447;

  // Bullet spawns at the shooter sprite centre; 10-bit sum wraps like the coordinate bus.
  function automatic logic [COORD_W-1:0] launch_coord(input logic [COORD_W-1:0] c);
    return c + COORD_W'(SPRITE_HALF);
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Two-flop synchronizer plus rising-edge detector; rise pulses for one clk, 2 cycles after the input edge.
// No backpressure; a level already high when reset releases never produces a pulse.
module frame_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [1:0] fill_q, fill_d;

  always_comb begin
    sync_d = {sync_q[0], async_in};
    prev_d = sync_q[1];
    fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      fill_q <= fill_d;
    end
  end

  // Edges are only trusted once both the synchronizer and prev hold real post-reset samples.
  assign rise = sync_q[1] & ~prev_q & (fill_q == 2'd3);

endmodule

// File: rtl/bullet_controller.sv
// Single-bullet launch/flight/cooldown controller; fire edge reaches LAUNCH one cycle after detection, outputs registered.
// No backpressure; shots outside IDLE are dropped. Define BULLET_COOLDOWN_EN to enable the COOLDOWN state.
module bullet_controller
  import game_pkg::*;
#(
  parameter int BULLET_SPEED    = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [1:0] dir,
  input  logic [9:0] ShooterX,
  input  logic [9:0] ShooterY,
  input  logic       remove_bullet,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic       bullet_status,
  output logic       is_shot
);

  localparam logic [10:0] SPEED = 11'(BULLET_SPEED);
  localparam logic [10:0] LIMIT = 11'(COORD_MAX);

`ifdef BULLET_COOLDOWN_EN
  localparam bullet_state_t KILL_ST = ST_COOLDOWN;
  localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam bullet_state_t KILL_ST = ST_IDLE;
`endif

  logic tick, shot_req;

  frame_tick u_frame_tick (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (frame_clk),
    .rise     (tick)
  );

  frame_tick u_fire_edge (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (fire),
    .rise     (shot_req)
  );

  bullet_state_t state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [9:0]    bullet_x_q, bullet_x_d;
  logic [9:0]    bullet_y_q, bullet_y_d;
  logic          bullet_status_q, bullet_status_d;
  logic          is_shot_q, is_shot_d;

  logic [10:0] cur_x, cur_y, step_x, step_y;
  logic        step_ok;
  logic        alive_d;

  assign cur_x = {1'b0, bullet_x_q};
  assign cur_y = {1'b0, bullet_y_q};

  // One step along the latched axis; step_ok drops when it would leave 0..1023.
  always_comb begin
    step_x  = cur_x;
    step_y  = cur_y;
    step_ok = 1'b1;
    case (dir_q)
      DIR_UP: begin
        step_ok = (cur_y >= SPEED);
        step_y  = cur_y - SPEED;
      end
      DIR_DOWN: begin
        step_y  = cur_y + SPEED;
        step_ok = ((cur_y + SPEED) <= LIMIT);
      end
      DIR_LEFT: begin
        step_ok = (cur_x >= SPEED);
        step_x  = cur_x - SPEED;
      end
      DIR_RIGHT: begin
        step_x  = cur_x + SPEED;
        step_ok = ((cur_x + SPEED) <= LIMIT);
      end
      default: step_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    bullet_x_d = bullet_x_q;
    bullet_y_d = bullet_y_q;
`ifdef BULLET_COOLDOWN_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (shot_req) begin
          state_d    = ST_LAUNCH;
          dir_d      = dir_t'(dir);
          bullet_x_d = launch_coord(ShooterX);
          bullet_y_d = launch_coord(ShooterY);
        end
      end
      ST_LAUNCH: begin
        state_d = remove_bullet ? KILL_ST : ST_FLYING;
      end
      ST_FLYING: begin
        // Removal takes priority so a killed bullet never takes a final step.
        if (remove_bullet) begin
          state_d = KILL_ST;
        end else if (tick) begin
          if (step_ok) begin
            bullet_x_d = step_x[9:0];
            bullet_y_d = step_y[9:0];
          end else begin
            state_d = KILL_ST;
          end
        end
      end
`ifdef BULLET_COOLDOWN_EN
      ST_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef BULLET_COOLDOWN_EN
    if (state_d == ST_COOLDOWN && state_q != ST_COOLDOWN) cnt_d = CNT_W'(COOLDOWN_FRAMES);
`endif

    alive_d = (state_d == ST_LAUNCH) || (state_d == ST_FLYING);
    if (!alive_d) begin
      bullet_x_d = '0;
      bullet_y_d = '0;
    end
    bullet_status_d = alive_d;
    is_shot_d       = (state_d == ST_LAUNCH);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= ST_IDLE;
      dir_q           <= DIR_UP;
      bullet_x_q      <= '0;
      bullet_y_q      <= '0;
      bullet_status_q <= 1'b0;
      is_shot_q       <= 1'b0;
`ifdef BULLET_COOLDOWN_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      bullet_x_q      <= bullet_x_d;
      bullet_y_q      <= bullet_y_d;
      bullet_status_q <= bullet_status_d;
      is_shot_q       <= is_shot_d;
`ifdef BULLET_COOLDOWN_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

  assign BulletX       = bullet_x_q;
  assign BulletY       = bullet_y_q;
  assign bullet_status = bullet_status_q;
  assign is_shot       = is_shot_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Scoreboard bench for bullet_controller: an event-level game model queues expected launch/move/death events,
// a negedge monitor pops and compares each event the DUT shows.
module tb_bullet_controller;

`ifdef BULLET_COOLDOWN_EN
  localparam int CD = 8;
`else
  localparam int CD = 0;
`endif
  localparam int SPD = 4;
  localparam int EV_LAUNCH = 0;
  localparam int EV_MOVE   = 1;
  localparam int EV_DEATH  = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       frame_clk = 1'b0;
  logic       fire = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [9:0] ShooterX = '0;
  logic [9:0] ShooterY = '0;
  logic       remove_bullet = 1'b0;
  logic [9:0] BulletX, BulletY;
  logic       bullet_status, is_shot;

  bullet_controller #(.BULLET_SPEED(SPD), .COOLDOWN_FRAMES(8)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_clk     (frame_clk),
    .fire          (fire),
    .dir           (dir),
    .ShooterX      (ShooterX),
    .ShooterY      (ShooterY),
    .remove_bullet (remove_bullet),
    .BulletX       (BulletX),
    .BulletY       (BulletY),
    .bullet_status (bullet_status),
    .is_shot       (is_shot)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int kind;
    int x;
    int y;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  task automatic check_eq(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic got_event(input int kind, input int x, input int y);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d (%0d,%0d), required no event", kind, x, y);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.x != x || e.y != y) begin
        n_fail++;
        $display("FAIL event: got kind=%0d (%0d,%0d), required kind=%0d (%0d,%0d)",
                 kind, x, y, e.kind, e.x, e.y);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic       p_status = 1'b0, p_shot = 1'b0;
  logic [9:0] p_x = '0, p_y = '0;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (!bullet_status) check_eq("dead_pos_zero", int'(BulletX) + int'(BulletY), 0);
      if (is_shot) begin
        check_eq("is_shot_width", int'(p_shot), 0);
        check_eq("status_in_launch", int'(bullet_status), 1);
        got_event(EV_LAUNCH, int'(BulletX), int'(BulletY));
      end else if (bullet_status && p_status && (BulletX != p_x || BulletY != p_y)) begin
        got_event(EV_MOVE, int'(BulletX), int'(BulletY));
      end else if (!bullet_status && p_status) begin
        got_event(EV_DEATH, int'(BulletX), int'(BulletY));
      end
    end
    p_status = bullet_status;
    p_shot   = is_shot;
    p_x      = BulletX;
    p_y      = BulletY;
  end

  // ---------------- reference model ----------------
  int m_state = 0;   // 0 idle, 1 alive, 2 cooling down
  int m_x, m_y, m_dir, m_cd;

  function automatic ev_t mk(input int k, input int x, input int y);
    ev_t e;
    e.kind = k; e.x = x; e.y = y;
    return e;
  endfunction

  task automatic m_fire(input int sx, input int sy, input int d);
    if (m_state == 0) begin
      m_x = (sx + 15) % 1024;
      m_y = (sy + 15) % 1024;
      m_dir = d;
      m_state = 1;
      exp_q.push_back(mk(EV_LAUNCH, m_x, m_y));
    end
  endtask

  task automatic m_kill();
    exp_q.push_back(mk(EV_DEATH, 0, 0));
    if (CD > 0) begin
      m_state = 2;
      m_cd = CD;
    end else begin
      m_state = 0;
    end
  endtask

  task automatic m_tick();
    int nx, ny;
    if (m_state == 1) begin
      nx = m_x; ny = m_y;
      case (m_dir)
        0: ny = m_y - SPD;
        1: ny = m_y + SPD;
        2: nx = m_x - SPD;
        default: nx = m_x + SPD;
      endcase
      if (nx < 0 || nx > 1023 || ny < 0 || ny > 1023) begin
        m_kill();
      end else begin
        m_x = nx; m_y = ny;
        exp_q.push_back(mk(EV_MOVE, m_x, m_y));
      end
    end else if (m_state == 2) begin
      m_cd--;
      if (m_cd == 0) m_state = 0;
    end
  endtask

  task automatic m_remove();
    if (m_state == 1) m_kill();
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_fire(input int sx, input int sy, input int d);
    ShooterX = 10'(sx); ShooterY = 10'(sy); dir = 2'(d);
    m_fire(sx, sy, d);
    fire = 1'b1; cyc(4);
    fire = 1'b0; cyc(4);
  endtask

  task automatic do_tick();
    m_tick();
    ShooterX = 10'($urandom_range(0, 1023));
    ShooterY = 10'($urandom_range(0, 1023));
    dir = 2'($urandom_range(0, 3));
    frame_clk = 1'b1; cyc(4);
    frame_clk = 1'b0; cyc(4);
  endtask

  task automatic do_remove();
    m_remove();
    remove_bullet = 1'b1; cyc(1);
    remove_bullet = 1'b0; cyc(3);
  endtask

  // remove_bullet lands in the same cycle the synchronized tick pulse is consumed
  task automatic do_tick_remove();
    if (m_state == 1) m_remove(); else m_tick();
    frame_clk = 1'b1; cyc(2);
    remove_bullet = 1'b1; cyc(1);
    remove_bullet = 1'b0; cyc(2);
    frame_clk = 1'b0; cyc(4);
  endtask

  function automatic int rnd_coord();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(0, 30);
      1:       return $urandom_range(990, 1023);
      default: return $urandom_range(0, 1023);
    endcase
  endfunction

  initial begin
    #2 Reset_n = 1'b0;
    cyc(3);
    check_eq("rst_BulletX", int'(BulletX), 0);
    check_eq("rst_BulletY", int'(BulletY), 0);
    check_eq("rst_status", int'(bullet_status), 0);
    check_eq("rst_is_shot", int'(is_shot), 0);
    Reset_n = 1'b1;
    mon_en = 1'b1;
    cyc(4);

    // launch to the right, three frame steps
    do_fire(100, 200, 3);
    repeat (3) do_tick();
    check_eq("flight_x_after_3", int'(BulletX), 127);
    check_eq("flight_y_after_3", int'(BulletY), 215);

    // shots during cooldown are dropped; first shot after the last cooldown tick launches
    do_remove();
    for (int i = 0; i < 8; i++) begin
      do_fire(rnd_coord(), rnd_coord(), int'($urandom_range(0, 3)));
      do_tick();
    end
    do_fire(400, 300, 1);

    // remove and tick in the same cycle at (300,215)
    do_remove();
    repeat (8) do_tick();
    do_fire(285, 200, 3);
    do_tick_remove();
    check_eq("kill_status", int'(bullet_status), 0);
    repeat (8) do_tick();

    // upward flight from the top edge self-terminates instead of wrapping
    do_fire(500, 0, 0);
    repeat (4) do_tick();
    repeat (8) do_tick();

    // fire held across 50 frames gives one shot
    ShooterX = 10'd100; ShooterY = 10'd100; dir = 2'd3;
    m_fire(100, 100, 3);
    fire = 1'b1; cyc(4);
    for (int i = 0; i < 50; i++) do_tick();
    fire = 1'b0; cyc(4);

    // reset mid-flight, with fire already high when reset releases
    mon_en = 1'b0;
    fire = 1'b1;
    Reset_n = 1'b0;
    #1;
    check_eq("midrst_BulletX", int'(BulletX), 0);
    check_eq("midrst_BulletY", int'(BulletY), 0);
    check_eq("midrst_status", int'(bullet_status), 0);
    check_eq("midrst_is_shot", int'(is_shot), 0);
    exp_q.delete();
    m_state = 0;
    cyc(3);
    Reset_n = 1'b1;
    mon_en = 1'b1;
    cyc(10);
    fire = 1'b0; cyc(4);

    // removal followed two cycles later by a new fire edge
    do_fire(200, 200, 1);
    m_remove();
    remove_bullet = 1'b1; cyc(1);
    remove_bullet = 1'b0; cyc(2);
    do_fire(300, 100, 2);
    repeat (8) do_tick();

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:          do_fire(rnd_coord(), rnd_coord(), int'($urandom_range(0, 3)));
        3, 4, 5, 6, 7:    do_tick();
        8:                do_remove();
        default:          do_tick_remove();
      endcase
    end

    cyc(10);
    check_eq("events_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
